// File: rtl/mult_pkg.sv
// Shared types, constants and helpers for the pipelined carry-save multiplier.
package mult_pkg;

   // Largest operand width the stage record can carry.
   localparam int unsigned MAX_W      = 32;
   localparam int unsigned IDX_W      = 6;
   localparam int unsigned DEF_WIDTH  = 16;
   localparam int unsigned DEF_STAGES = 4;

   function automatic int unsigned rows_per_stage(input int unsigned width,
                                                  input int unsigned stages);
      return width / stages;
   endfunction

   localparam int unsigned ROWS_PER_STAGE = rows_per_stage(DEF_WIDTH, DEF_STAGES);

   // Baugh-Wooley correction: 2^W + 2^(2W-1), compensating the inverted MSB terms.
   function automatic logic [2*MAX_W-1:0] bw_corr(input int unsigned width);
      logic [2*MAX_W-1:0] one;
      one = {{(2*MAX_W-1){1'b0}}, 1'b1};
      return (one << width) | (one << (2*width - 1));
   endfunction

   // One pipeline stage: operands travel with the partial carry-save result.
   typedef struct packed {
      logic                 valid;
      logic                 sgn;
      logic [MAX_W-1:0]     a;
      logic [MAX_W-1:0]     b;
      logic [2*MAX_W-1:0]   sum;
      logic [2*MAX_W-1:0]   carry;
      logic [IDX_W-1:0]     row_idx;   // partial-product rows already reduced
   } stage_t;

endpackage

// File: rtl/csa_mult_pipe_if.sv
// Operand/result handshake bundle for csa_mult_pipe.
interface csa_mult_pipe_if #(
   parameter int unsigned WIDTH = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               sgn;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out;

   // Producer/consumer side.
   modport master (
      output in_valid, a, b, sgn, out_ready,
      input  in_ready, out_valid, out
   );

   // Multiplier side.
   modport slave (
      input  in_valid, a, b, sgn, out_ready,
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/csa_row.sv
// One carry-save row: folds a shifted, gated partial-product row into a sum/carry pair.
// carry is kept unshifted; the represented value is sum + (carry << 1) mod 2^(2W).
module csa_row
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned ROW   = 0
) (
   input  logic [WIDTH-1:0]   a_i,
   input  logic               b_bit_i,
   input  logic               sgn_i,
   input  logic [2*WIDTH-1:0] sum_i,
   input  logic [2*WIDTH-1:0] carry_i,
   output logic [2*WIDTH-1:0] sum_o,
   output logic [2*WIDTH-1:0] carry_o
);
   localparam int unsigned PW = 2*WIDTH;

   logic [WIDTH-1:0] pp_raw;
   logic [WIDTH-1:0] pp;
   logic [PW-1:0]    pp_ext;
   logic [PW-1:0]    x;
   logic [PW-1:0]    y;
   logic             unused_carry_msb;

   // Partial-product row with the Baugh-Wooley inversions for signed operands.
   always_comb begin
      pp_raw = a_i & {WIDTH{b_bit_i}};
      pp     = pp_raw;
      if (sgn_i) begin
         if (ROW == WIDTH-1) begin
            pp = {pp_raw[WIDTH-1], ~pp_raw[WIDTH-2:0]};
         end else begin
            pp[WIDTH-1] = ~pp_raw[WIDTH-1];
         end
      end
   end

   assign pp_ext = PW'(pp) << ROW;
   assign x      = sum_i;
   assign y      = {carry_i[PW-2:0], 1'b0};

   // Full adders across the product width; the carry out of the top bit is dropped (mod 2^(2W)).
   assign sum_o   = x ^ y ^ pp_ext;
   assign carry_o = (x & y) | (x & pp_ext) | (y & pp_ext);

   assign unused_carry_msb = carry_i[PW-1];
endmodule

// File: rtl/csa_mult_pipe.sv
// Pipelined carry-save array multiplier with a global valid/ready stall.
// Input register -> STAGES carry-save stages -> registered carry-propagate adder.
module csa_mult_pipe
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned STAGES = DEF_STAGES
) (
   input  logic            clk,
   input  logic            reset,
   csa_mult_pipe_if.slave  bus
);
   localparam int unsigned RPS = rows_per_stage(WIDTH, STAGES);
   localparam int unsigned PW  = 2*WIDTH;

   stage_t        st_q [STAGES+1];
   stage_t        st_d [STAGES+1];
   stage_t        st0_d;
   logic [PW-1:0] out_q;
   logic [PW-1:0] out_d;
   logic          out_valid_q;
   logic          stall;
   logic          accept;
   logic          unused_stage_bits;

   assign stall         = out_valid_q & ~bus.out_ready;
   assign accept        = bus.in_valid & ~stall;
   assign bus.in_ready  = ~stall;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;

   // Input register: capture operands and seed the sum with the signed-mode correction.
   always_comb begin
      st0_d       = st_q[0];
      st0_d.valid = accept;
      if (accept) begin
         st0_d.sgn     = bus.sgn;
         st0_d.a       = MAX_W'(bus.a);
         st0_d.b       = MAX_W'(bus.b);
         st0_d.sum     = bus.sgn ? bw_corr(WIDTH) : '0;
         st0_d.carry   = '0;
         st0_d.row_idx = '0;
      end
   end

   assign st_d[0] = st0_d;

   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      logic [PW-1:0] sum_w   [RPS+1];
      logic [PW-1:0] carry_w [RPS+1];
      stage_t        nxt;

      assign sum_w[0]   = st_q[k-1].sum[PW-1:0];
      assign carry_w[0] = st_q[k-1].carry[PW-1:0];

      for (genvar j = 0; j < RPS; j++) begin : g_row
         csa_row #(
            .WIDTH (WIDTH),
            .ROW   ((k-1)*RPS + j)
         ) u_row (
            .a_i     (st_q[k-1].a[WIDTH-1:0]),
            .b_bit_i (st_q[k-1].b[(k-1)*RPS + j]),
            .sgn_i   (st_q[k-1].sgn),
            .sum_i   (sum_w[j]),
            .carry_i (carry_w[j]),
            .sum_o   (sum_w[j+1]),
            .carry_o (carry_w[j+1])
         );
      end

      // Stage result: operands pass through, sum/carry take this stage's reduction.
      always_comb begin
         nxt         = st_q[k-1];
         nxt.sum     = (2*MAX_W)'(sum_w[RPS]);
         nxt.carry   = (2*MAX_W)'(carry_w[RPS]);
         nxt.row_idx = IDX_W'(k*RPS);
      end

      assign st_d[k] = nxt;
   end

   // The only carry-propagate adder.
   assign out_d = st_q[STAGES].sum[PW-1:0] + {st_q[STAGES].carry[PW-2:0], 1'b0};

   // Pipeline registers: everything holds while the consumer stalls the output.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k <= STAGES; k++) begin
            st_q[k].valid <= 1'b0;
         end
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (!stall) begin
         for (int unsigned k = 0; k <= STAGES; k++) begin
            st_q[k] <= st_d[k];
         end
         out_valid_q <= st_q[STAGES].valid;
         if (st_q[STAGES].valid) begin
            out_q <= out_d;
         end
      end
   end

   // Record bits beyond WIDTH are never consumed.
   always_comb begin
      unused_stage_bits = 1'b0;
      for (int unsigned k = 0; k <= STAGES; k++) begin
         unused_stage_bits = unused_stage_bits ^ (^st_q[k]);
      end
   end
endmodule

// File: tb/tb_csa_mult_pipe.sv
module tb_csa_mult_pipe;
   localparam int LAT16 = 5;
   localparam int NRAND = 1000;
   localparam int RAND_LIMIT = 20000;

   logic clk = 1'b0;
   logic reset;
   int   errors;
   int   checks;

   always #5 clk = ~clk;

   csa_mult_pipe_if #(.WIDTH(16)) if16 ();
   csa_mult_pipe_if #(.WIDTH(8))  if8  ();

   csa_mult_pipe #(.WIDTH(16), .STAGES(4)) u_dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (if16)
   );

   csa_mult_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (if8)
   );

   typedef struct {
      logic        vld;
      logic [15:0] a;
      logic [15:0] b;
      logic        sgn;
      logic [31:0] exp;
   } vec_t;

   vec_t tab [18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
      logic [31:0] ax, bx;
      ax = s ? {{16{a[15]}}, a} : {16'h0000, a};
      bx = s ? {{16{b[15]}}, b} : {16'h0000, b};
      return ax * bx;
   endfunction

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
      logic [15:0] ax, bx;
      ax = s ? {{8{a[7]}}, a} : {8'h00, a};
      bx = s ? {{8{b[7]}}, b} : {8'h00, b};
      return ax * bx;
   endfunction

   function automatic logic [15:0] rop16();
      case ($urandom_range(0, 7))
         0:       return 16'h8000;
         1:       return 16'hFFFF;
         2:       return 16'h7FFF;
         3:       return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [7:0] rop8();
      case ($urandom_range(0, 7))
         0:       return 8'h80;
         1:       return 8'hFF;
         2:       return 8'h7F;
         3:       return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic s);
      if16.in_valid = v;
      if16.a        = a;
      if16.b        = b;
      if16.sgn      = s;
   endtask

   // Stream tab[first +: n] one slot per cycle with out_ready high, checking every cycle.
   task automatic run_seq(input int first, input int n, input string tag);
      for (int e = 0; e < n + LAT16; e++) begin
         if (e < n) drive16(tab[first+e].vld, tab[first+e].a, tab[first+e].b, tab[first+e].sgn);
         else       drive16(1'b0, 16'h0, 16'h0, 1'b0);
         @(posedge clk); #1;
         chk($sformatf("%s in_ready c%0d", tag, e), 64'(if16.in_ready), 64'd1);
         if (e >= LAT16) begin
            chk($sformatf("%s out_valid[%0d]", tag, e - LAT16), 64'(if16.out_valid),
                64'(tab[first+e-LAT16].vld));
            if (tab[first+e-LAT16].vld)
               chk($sformatf("%s out[%0d]", tag, e - LAT16), 64'(if16.out),
                   64'(tab[first+e-LAT16].exp));
         end else begin
            chk($sformatf("%s early out_valid c%0d", tag, e), 64'(if16.out_valid), 64'd0);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q16 [$];
      logic [15:0] q8  [$];
      int acc16, acc8, cyc;

      errors = 0;
      checks = 0;
      reset  = 1'b1;
      drive16(1'b0, 16'h0, 16'h0, 1'b0);
      if16.out_ready = 1'b1;
      if8.in_valid   = 1'b0;
      if8.a          = '0;
      if8.b          = '0;
      if8.sgn        = 1'b0;
      if8.out_ready  = 1'b1;

      tab[0]  = '{1'b1, 16'd2057, 16'd145, 1'b0, 32'd298265};
      tab[1]  = '{1'b1, 16'd2057, 16'd145, 1'b0, 32'd298265};
      tab[2]  = '{1'b1, 16'd2077, 16'd25,  1'b0, 32'd51925};
      tab[3]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
      tab[4]  = '{1'b1, 16'hFFFD, 16'd5,    1'b1, 32'hFFFFFFF1};
      tab[5]  = '{1'b1, 16'hFFFD, 16'd5,    1'b0, 32'h0004FFF1};
      tab[6]  = '{1'b1, 16'h8000, 16'h8000, 1'b1, 32'h40000000};
      tab[7]  = '{1'b1, 16'h7FFF, 16'h8000, 1'b0, 32'h3FFF8000};
      tab[8]  = '{1'b1, 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
      tab[9]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
      tab[10] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
      tab[11] = '{1'b1, 16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF};
      tab[12] = '{1'b1, 16'd3,    16'd7,    1'b0, 32'd21};
      tab[13] = '{1'b0, 16'h0,    16'h0,    1'b0, 32'h0};
      tab[14] = '{1'b1, 16'd1234, 16'd5678, 1'b0, 32'd7006652};
      tab[15] = '{1'b0, 16'h0,    16'h0,    1'b0, 32'h0};
      tab[16] = '{1'b1, 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE};
      tab[17] = '{1'b0, 16'h0,    16'h0,    1'b0, 32'h0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 64'(if16.out_valid), 64'd0);
      chk("reset out", 64'(if16.out), 64'd0);
      chk("reset in_ready", 64'(if16.in_ready), 64'd1);
      chk("reset out_valid w8", 64'(if8.out_valid), 64'd0);
      reset = 1'b0;

      run_seq(0, 1, "single");
      run_seq(1, 3, "b2b");
      run_seq(4, 8, "signed");

      // Backpressure: three pairs in flight, output held for three cycles.
      drive16(1'b1, 16'd100, 16'd3, 1'b0);    @(posedge clk); #1;
      drive16(1'b1, 16'd7,   16'd9, 1'b0);    @(posedge clk); #1;
      drive16(1'b1, 16'hFFFE, 16'd3, 1'b1);   @(posedge clk); #1;
      drive16(1'b0, 16'h0, 16'h0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      chk("bp first valid", 64'(if16.out_valid), 64'd1);
      chk("bp first out", 64'(if16.out), 64'd300);
      if16.out_ready = 1'b0;
      drive16(1'b1, 16'd1, 16'd1, 1'b0);
      #1;
      chk("bp in_ready low", 64'(if16.in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("bp hold valid %0d", i), 64'(if16.out_valid), 64'd1);
         chk($sformatf("bp hold out %0d", i), 64'(if16.out), 64'd300);
         chk($sformatf("bp hold in_ready %0d", i), 64'(if16.in_ready), 64'd0);
      end
      drive16(1'b0, 16'h0, 16'h0, 1'b0);
      if16.out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 64'(if16.in_ready), 64'd1);
      @(posedge clk); #1;
      chk("bp second valid", 64'(if16.out_valid), 64'd1);
      chk("bp second out", 64'(if16.out), 64'd63);
      @(posedge clk); #1;
      chk("bp third valid", 64'(if16.out_valid), 64'd1);
      chk("bp third out", 64'(if16.out), 64'hFFFFFFFA);
      for (int i = 0; i < LAT16; i++) begin
         @(posedge clk); #1;
         chk($sformatf("bp drained %0d", i), 64'(if16.out_valid), 64'd0);
      end

      run_seq(12, 6, "bubble");

      // Reset with five pairs in flight, the first about to reach the output.
      for (int i = 0; i < 5; i++) begin
         drive16(1'b1, 16'd2057, 16'd145, 1'b0);
         @(posedge clk); #1;
      end
      drive16(1'b0, 16'h0, 16'h0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midreset out_valid", 64'(if16.out_valid), 64'd0);
      chk("midreset in_ready", 64'(if16.in_ready), 64'd1);
      chk("midreset out", 64'(if16.out), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < LAT16 + 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("midreset stale %0d", i), 64'(if16.out_valid), 64'd0);
      end

      // Random traffic on both configurations with random backpressure.
      acc16 = 0;
      acc8  = 0;
      cyc   = 0;
      while ((acc16 < NRAND || q16.size() != 0 || acc8 < NRAND || q8.size() != 0) &&
             cyc < RAND_LIMIT) begin
         drive16((acc16 < NRAND) && ($urandom_range(0, 3) != 0), rop16(), rop16(),
                 1'($urandom_range(0, 1)));
         if16.out_ready = ($urandom_range(0, 3) != 0);
         if8.in_valid   = (acc8 < NRAND) && ($urandom_range(0, 3) != 0);
         if8.a          = rop8();
         if8.b          = rop8();
         if8.sgn        = 1'($urandom_range(0, 1));
         if8.out_ready  = ($urandom_range(0, 3) != 0);
         #1;
         if (if16.out_valid && if16.out_ready) begin
            if (q16.size() == 0) chk("rand16 extra result", 64'(if16.out_valid), 64'd0);
            else chk($sformatf("rand16 out c%0d", cyc), 64'(if16.out), 64'(q16.pop_front()));
         end
         if (if16.in_valid && if16.in_ready) begin
            q16.push_back(model16(if16.a, if16.b, if16.sgn));
            acc16++;
         end
         if (if8.out_valid && if8.out_ready) begin
            if (q8.size() == 0) chk("rand8 extra result", 64'(if8.out_valid), 64'd0);
            else chk($sformatf("rand8 out c%0d", cyc), 64'(if8.out), 64'(q8.pop_front()));
         end
         if (if8.in_valid && if8.in_ready) begin
            q8.push_back(model8(if8.a, if8.b, if8.sgn));
            acc8++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("rand within cycle budget", 64'(cyc < RAND_LIMIT), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
